// File: rtl/mac_pkg.sv
// mac_pkg: shared constants, fp32 type and NaN test for the MAC result path
package mac_pkg;
  localparam int MAC_LATENCY = 15;
  localparam int MAC_WIDTH = 32;
  typedef logic [31:0] fp32_t;
  function automatic logic is_nan(fp32_t x);
    return (&x[30:23]) && (|x[22:0]);
  endfunction
endpackage

// File: rtl/mac_result_fifo.sv
// mac_result_fifo: synchronous FIFO with wrap-bit pointers for buffered MAC results
module mac_result_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wr_ptr, rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata = mem[rd_ptr[AW-1:0]];
  // pointer advance; the wrap bit distinguishes full from empty
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  // storage array, no reset needed since contents are qualified by the pointers
  always_ff @(posedge clock)
    if (push && !full) mem[wr_ptr[AW-1:0]] <= wdata;
  a_no_overflow: assert property (@(posedge clock) disable iff (!resetn) !(push && full));
endmodule

// File: rtl/mac_result_collector.sv
// mac_result_collector: rebuilds MAC result validity, buffers results, credit back-pressure (optional MAC_COLLECT_NAN_DETECT_EN)
module mac_result_collector
  import mac_pkg::*;
#(
  parameter int LATENCY = MAC_LATENCY,
  parameter int DEPTH = 16,
  parameter int WIDTH = MAC_WIDTH
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             ivalid,
  output logic             oready,
  input  logic [WIDTH-1:0] pipe_data,
  output logic             ovalid,
  input  logic             iready,
  output logic [WIDTH-1:0] dataout,
  output logic             nan_flag
);
  localparam int RW = $clog2(DEPTH + 1);
  logic [LATENCY-1:0] valid_line;
  logic [RW-1:0] reserved;
  logic issue, pop, push, full, empty;
  assign oready = reserved < RW'(DEPTH);
  assign issue = ivalid && oready;
  assign pop = ovalid && iready;
  assign push = valid_line[LATENCY-1];
  assign ovalid = !empty;
  // valid delay line matched to the MAC pipeline depth
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) valid_line <= '0;
    else valid_line <= {valid_line[LATENCY-2:0], issue};
  // credit counter: results issued and not yet popped
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) reserved <= '0;
    else if (issue && !pop) reserved <= reserved + 1'b1;
    else if (pop && !issue) reserved <= reserved - 1'b1;
  mac_result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clock (clock),
    .resetn(resetn),
    .push  (push),
    .pop   (pop),
    .wdata (pipe_data),
    .rdata (dataout),
    .full  (full),
    .empty (empty)
  );
`ifdef MAC_COLLECT_NAN_DETECT_EN
  // sticky NaN flag, set by any NaN result written into the FIFO
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) nan_flag <= 1'b0;
    else if (push && is_nan(fp32_t'(pipe_data))) nan_flag <= 1'b1;
`else
  assign nan_flag = 1'b0;
`endif
endmodule

// File: tb/tb_mac_result_collector.sv
// tb_mac_result_collector: table vectors, corner sequences and random traffic against a queue model
module tb_mac_result_collector;
  localparam int LAT = 15;
  localparam int DEP = 16;
  localparam int W = 32;
  localparam int HN = 8192;
`ifdef MAC_COLLECT_NAN_DETECT_EN
  localparam bit NAN_EN = 1'b1;
`else
  localparam bit NAN_EN = 1'b0;
`endif
  logic clock = 1'b0;
  logic resetn = 1'b0;
  logic ivalid = 1'b0;
  logic iready = 1'b0;
  logic [W-1:0] pipe_data = '0;
  logic oready, ovalid, nan_flag;
  logic [W-1:0] dataout;
  mac_result_collector #(.LATENCY(LAT), .DEPTH(DEP), .WIDTH(W)) dut (
    .clock    (clock),
    .resetn   (resetn),
    .ivalid   (ivalid),
    .oready   (oready),
    .pipe_data(pipe_data),
    .ovalid   (ovalid),
    .iready   (iready),
    .dataout  (dataout),
    .nan_flag (nan_flag)
  );
  always #5 clock = ~clock;
  typedef struct {
    logic [W-1:0] d;
    int avail;
  } ent_t;
  typedef struct {
    logic [W-1:0] d;
    bit nan;
  } vec_t;
  ent_t q[$];
  logic [W-1:0] opnd [HN];
  bit iss [HN];
  int cyc = 0;
  bit nan_m = 1'b0;
  int checks = 0;
  int errors = 0;
  function automatic bit fnan(logic [W-1:0] d);
    return d[30:23] == 8'hFF && d[22:0] != 23'd0;
  endfunction
  function automatic bit exp_ov();
    return q.size() > 0 && q[0].avail <= cyc;
  endfunction
  task automatic chk(input string n, input logic [W-1:0] a, input logic [W-1:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", n, cyc, a, e);
    end
  endtask
  task automatic check_all();
    chk("ovalid", {31'd0, ovalid}, {31'd0, exp_ov()});
    chk("oready", {31'd0, oready}, {31'd0, q.size() < DEP});
    if (exp_ov()) chk("dataout", dataout, q[0].d);
    chk("nan_flag", {31'd0, nan_flag}, {31'd0, nan_m});
  endtask
  task automatic step(input logic iv, input logic ir, input logic [W-1:0] d, output bit acc);
    bit pop, push;
    logic [W-1:0] pd;
    if (cyc >= HN - 1) begin
      $display("FAIL cycle_budget cyc=%0d got=overrun exp=within %0d", cyc, HN);
      errors++;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "cycle budget exhausted");
    end
    ivalid = iv;
    iready = ir;
    opnd[cyc] = d;
    pd = cyc >= LAT ? opnd[cyc-LAT] : $urandom;
    pipe_data = pd;
    acc = iv && q.size() < DEP;
    pop = ir && exp_ov();
    push = cyc >= LAT && iss[cyc-LAT];
    iss[cyc] = acc;
    @(posedge clock);
    if (pop) void'(q.pop_front());
    if (acc) q.push_back('{d, cyc + LAT + 1});
    if (push && NAN_EN && fnan(pd)) nan_m = 1'b1;
    cyc++;
    @(negedge clock);
    check_all();
  endtask
  task automatic do_reset();
    resetn = 1'b0;
    #1;
    chk("rst_ovalid", {31'd0, ovalid}, 32'd0);
    chk("rst_oready", {31'd0, oready}, 32'd1);
    chk("rst_nan", {31'd0, nan_flag}, 32'd0);
    q.delete();
    nan_m = 1'b0;
    for (int i = 0; i < HN; i++) iss[i] = 1'b0;
    ivalid = 1'b0;
    iready = 1'b0;
    opnd[cyc] = $urandom;
    pipe_data = cyc >= LAT ? opnd[cyc-LAT] : '0;
    @(posedge clock);
    cyc++;
    @(negedge clock);
    resetn = 1'b1;
  endtask
  initial begin
    vec_t tbl [7];
    bit a;
    int n, guard;
    tbl[0] = '{32'h3F800000, 1'b0};
    tbl[1] = '{32'h7F800000, 1'b0};
    tbl[2] = '{32'h00000000, 1'b0};
    tbl[3] = '{32'hFF800000, 1'b0};
    tbl[4] = '{32'h7FC00000, 1'b1};
    tbl[5] = '{32'h3F800000, 1'b1};
    tbl[6] = '{32'h7F800001, 1'b1};
    @(negedge clock);
    do_reset();
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 1'b0, tbl[i].d, a);
      repeat (14) step(1'b0, 1'b0, $urandom, a);
      chk("tbl_early_ovalid", {31'd0, ovalid}, 32'd0);
      step(1'b0, 1'b0, $urandom, a);
      chk("tbl_ovalid", {31'd0, ovalid}, 32'd1);
      chk("tbl_data", dataout, tbl[i].d);
      chk("tbl_nan", {31'd0, nan_flag}, {31'd0, tbl[i].nan & NAN_EN});
      chk("tbl_oready", {31'd0, oready}, 32'd1);
      step(1'b0, 1'b1, $urandom, a);
    end
    do_reset();
    for (int i = 0; i < DEP; i++) step(1'b1, 1'b0, 32'h100 + i, a);
    chk("fill_oready", {31'd0, oready}, 32'd0);
    step(1'b1, 1'b0, 32'hDEADBEEF, a);
    repeat (20) step(1'b0, 1'b0, $urandom, a);
    chk("full_ovalid", {31'd0, ovalid}, 32'd1);
    chk("full_head", dataout, 32'h100);
    step(1'b0, 1'b1, $urandom, a);
    chk("pop_oready", {31'd0, oready}, 32'd1);
    chk("pop_head", dataout, 32'h101);
    step(1'b1, 1'b0, 32'h200, a);
    chk("reissue_oready", {31'd0, oready}, 32'd0);
    repeat (40) step(1'b0, 1'b1, $urandom, a);
    n = 1;
    guard = 0;
    while (n <= 64 && guard < 500) begin
      step(1'b1, 1'b1, n, a);
      if (a) n++;
      guard++;
    end
    chk("stream_done", n, 65);
    repeat (25) step(1'b0, 1'b1, $urandom, a);
    repeat (3) step(1'b0, 1'b0, $urandom, a);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'h7FC00000, a);
    do_reset();
    repeat (25) step(1'b0, 1'b1, $urandom, a);
    for (int i = 0; i < 2000; i++) begin
      if (i == 1000) do_reset();
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
           ($urandom_range(0, 15) == 0) ? 32'h7FC00001 : $urandom, a);
    end
    repeat (60) step(1'b0, 1'b1, $urandom, a);
    chk("drained_ovalid", {31'd0, ovalid}, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
